// File: rtl/unary_stream_pkg.sv
// Shared types and sizing helpers for the serialised unary (thermometer) encoder.
package unary_stream_pkg;

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} fsm_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Beats needed to carry the largest count, 2**w_data-1 ones.
    function automatic int n_beats_of(input int w_data, input int w_beat);
        return ceil_div((1 << w_data) - 1, w_beat);
    endfunction

    function automatic int w_idx_of(input int n_beats);
        return (n_beats > 1) ? $clog2(n_beats) : 1;
    endfunction

endpackage

// File: rtl/unary_stream_if.sv
// Valid/ready stream link with a single data bus.
interface dti #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input  ready);
    modport consumer (input  valid, input  data, output ready);
endinterface

// File: rtl/unary_slice.sv
// Combinational thermometer slice: bit i is set while i is below the remaining count.
module unary_slice #(
    parameter int W_BEAT = 16,
    parameter int W_REM  = 9
) (
    input  logic [W_REM-1:0]  rem,
    output logic [W_BEAT-1:0] slice
);
    for (genvar i = 0; i < W_BEAT; i++) begin : g_bit
        assign slice[i] = (32'(i) < 32'(rem));
    end
endmodule

// File: rtl/unary_stream.sv
// Binary count in, LSB-first unary stream out, one W_BEAT slice per beat plus an eot flag.
// Optional clamp of the loaded count to MAX_CNT when UNARY_STREAM_SAT_EN is defined.
module unary_stream
    import unary_stream_pkg::*;
#(
    parameter int W_DATA  = 8,
    parameter int W_BEAT  = 16,
    parameter int TRIM    = 0,
    parameter int MAX_CNT = (1 << W_DATA) - 1
) (
    input  logic        clk,
    input  logic        rst,
    dti.consumer        din,
    dti.producer        dout
);
    localparam int N_BEATS = n_beats_of(W_DATA, W_BEAT);
    localparam int W_IDX   = w_idx_of(N_BEATS);
    localparam int W_REM   = W_DATA + 1;

    fsm_t              state, state_nxt;
    logic [W_REM-1:0]  rem, rem_nxt, n_ld;
    logic [W_IDX-1:0]  idx, idx_nxt;
    logic [W_BEAT-1:0] slice;
    logic              busy, eot, out_hs, in_hs;

    unary_slice #(.W_BEAT(W_BEAT), .W_REM(W_REM)) u_slice (.rem(rem), .slice(slice));

    assign busy = (state == EMIT);

    always_comb begin
        if (TRIM != 0) eot = (32'(rem) <= 32'(W_BEAT));
        else           eot = (idx == W_IDX'(N_BEATS - 1));
    end

`ifdef UNARY_STREAM_SAT_EN
    assign n_ld = ({1'b0, din.data} > W_REM'(MAX_CNT)) ? W_REM'(MAX_CNT) : {1'b0, din.data};
`else
    assign n_ld = {1'b0, din.data};
`endif

    // Gate with busy so an idle link shows all-zero data even when N_BEATS=1.
    assign dout.valid = busy;
    assign dout.data  = busy ? {eot, slice} : '0;
    assign out_hs     = busy && dout.ready;
    assign din.ready  = !busy || (out_hs && eot);
    assign in_hs      = din.valid && din.ready;

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        idx_nxt   = idx;
        if (in_hs) begin
            // Load wins over the eot retire of the previous frame.
            state_nxt = EMIT;
            rem_nxt   = n_ld;
            idx_nxt   = '0;
        end else if (out_hs) begin
            if (eot) begin
                state_nxt = IDLE;
                rem_nxt   = '0;
                idx_nxt   = '0;
            end else begin
                rem_nxt = (32'(rem) > 32'(W_BEAT)) ? W_REM'(32'(rem) - 32'(W_BEAT)) : '0;
                idx_nxt = idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rem   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            idx   <= idx_nxt;
        end
    end
endmodule

// File: tb/tb_unary_stream.sv
// Scoreboarded directed bench: one TRIM=0 and one TRIM=1 encoder, W_DATA=4, W_BEAT=4.
module tb_unary_stream;
    logic clk = 0;
    logic rst_n;
    always #5 clk = ~clk;

    dti #(.W(4)) din0 ();
    dti #(.W(5)) dout0 ();
    dti #(.W(4)) din1 ();
    dti #(.W(5)) dout1 ();

    unary_stream #(.W_DATA(4), .W_BEAT(4), .TRIM(0)) u0 (
        .clk(clk), .rst(rst_n), .din(din0), .dout(dout0));
    unary_stream #(.W_DATA(4), .W_BEAT(4), .TRIM(1), .MAX_CNT(10)) u1 (
        .clk(clk), .rst(rst_n), .din(din1), .dout(dout1));

    int vecs = 0;
    int errs = 0;
    logic [4:0] q0[$];
    logic [4:0] q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && dout0.valid && dout0.ready) begin
            if (q0.size() == 0) check("u0 unexpected beat", 32'(dout0.data), 32'h1ff);
            else check("u0 beat", 32'(dout0.data), 32'(q0.pop_front()));
        end
        if (rst_n && dout1.valid && dout1.ready) begin
            if (q1.size() == 0) check("u1 unexpected beat", 32'(dout1.data), 32'h1ff);
            else check("u1 beat", 32'(dout1.data), 32'(q1.pop_front()));
        end
    end

    // Called right after a posedge; returns #1 after the handshake edge.
    task automatic send(input int which, input logic [3:0] n);
        bit done = 0;
        if (which == 0) begin din0.valid = 1; din0.data = n; end
        else            begin din1.valid = 1; din1.data = n; end
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            done = (which == 0) ? din0.ready : din1.ready;
            @(posedge clk); #1;
        end
        if (!done) check("din handshake timeout", 0, 1);
        if (which == 0) din0.valid = 0; else din1.valid = 0;
    endtask

    task automatic drain();
        int c = 0;
        while ((q0.size() != 0 || q1.size() != 0) && c < 100) begin
            @(posedge clk); #1; c++;
        end
        check("drain", 32'(q0.size() + q1.size()), 0);
    endtask

    initial begin
        rst_n = 0;
        din0.valid = 0; din0.data = 0; dout0.ready = 1;
        din1.valid = 0; din1.data = 0; dout1.ready = 1;
        #1;
        check("rst u0 valid", 32'(dout0.valid), 0);
        check("rst u0 data", 32'(dout0.data), 0);
        check("rst u1 valid", 32'(dout1.valid), 0);
        check("rst u1 din.ready", 32'(din1.ready), 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // TRIM=0, N=6, with first-beat latency check
        q0.push_back(5'h0F); q0.push_back(5'h03); q0.push_back(5'h00); q0.push_back(5'h10);
        send(0, 4'd6);
        check("u0 latency valid", 32'(dout0.valid), 1);
        check("u0 first beat", 32'(dout0.data), 32'h0F);
        drain();

        // TRIM=0, N=0 -> four empty beats; N=15 -> last beat partial
        q0.push_back(5'h00); q0.push_back(5'h00); q0.push_back(5'h00); q0.push_back(5'h10);
        send(0, 4'd0);
        drain();
        q0.push_back(5'h0F); q0.push_back(5'h0F); q0.push_back(5'h0F); q0.push_back(5'h17);
        send(0, 4'd15);
        drain();

        // TRIM=1 basics
        q1.push_back(5'h0F); q1.push_back(5'h13);
        send(1, 4'd6);
        drain();
        q1.push_back(5'h0F); q1.push_back(5'h1F);
        send(1, 4'd8);
        drain();
        q1.push_back(5'h10);
        send(1, 4'd0);
        drain();

        // Backpressure on beat 2 of N=15
        q1.push_back(5'h0F); q1.push_back(5'h0F);
`ifdef UNARY_STREAM_SAT_EN
        q1.push_back(5'h13);
`else
        q1.push_back(5'h0F); q1.push_back(5'h17);
`endif
        send(1, 4'd15);
        @(posedge clk); #1;
        dout1.ready = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp valid", 32'(dout1.valid), 1);
            check("bp data", 32'(dout1.data), 32'h0F);
            check("bp din.ready", 32'(din1.ready), 0);
        end
        @(posedge clk); #1 dout1.ready = 1;
        drain();

        // Back-to-back frames, ready must be high on the eot beat
        q1.push_back(5'h0F); q1.push_back(5'h11); q1.push_back(5'h13);
        send(1, 4'd5);
        check("b2b beat1", 32'(dout1.data), 32'h0F);
        send(1, 4'd2);
        check("b2b next frame", 32'(dout1.data), 32'h13);
        drain();

        // Asynchronous reset mid-frame
        q1.push_back(5'h0F);
        send(1, 4'd15);
        @(posedge clk); #2;
        rst_n = 0;
        q1.delete();
        #1;
        check("async rst valid", 32'(dout1.valid), 0);
        check("async rst data", 32'(dout1.data), 0);
        @(posedge clk); #1 rst_n = 1;
        check("post rst din.ready", 32'(din1.ready), 1);
        q1.push_back(5'h17);
        send(1, 4'd3);
        drain();
        check("idle after frame", 32'(dout1.valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
